// File: rtl/bool_lut_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : bool_lut_evaluator
// Description : Programmable truth-table evaluator. Loads a genome as a stream
//               of CFG_W-bit words, answers single-vector queries and runs a
//               match-count fitness sweep against a target table.
//               Optional best-score tracking when BOOL_LUT_BEST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bool_lut_evaluator #(
    parameter  int NUM_IN  = 4,
    parameter  int NUM_OUT = 4,
    parameter  int CFG_W   = 8,
    localparam int T       = 1 << NUM_IN,
    localparam int G       = NUM_OUT * T,
    localparam int SCORE_W = $clog2(G + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CFG_W-1:0]   cfg_data,
    input  logic               in_valid,
    input  logic [NUM_IN-1:0]  in_vec,
    output logic               out_valid,
    output logic [NUM_OUT-1:0] out_vec,
    input  logic               eval_start,
    input  logic [G-1:0]       target_tbl,
    output logic               eval_busy,
    output logic               eval_done,
    output logic [SCORE_W-1:0] score
`ifdef BOOL_LUT_BEST_EN
    ,
    output logic [SCORE_W-1:0] best_score
`endif
);

    localparam int c_words   = G / CFG_W;
    localparam int c_cnt_w   = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int c_match_w = $clog2(NUM_OUT + 1);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_ready = 2'd2;
    localparam logic [1:0] c_st_sweep = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [G-1:0]         r_genome;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_widx;
    logic [NUM_IN-1:0]    r_v;
    logic [SCORE_W-1:0]   r_acc;
    logic [SCORE_W-1:0]   w_final;
    logic [c_match_w-1:0] w_match;
    logic [NUM_OUT-1:0]   w_lookup;
    logic [NUM_OUT-1:0]   w_hit;
    logic                 w_xfer;
    logic                 w_last_word;
    logic                 w_last_vec;
    logic                 w_query;

    assign w_xfer      = cfg_valid && cfg_ready;
    // The first word of a load always lands in slot 0, even when reloading from READY.
    assign w_widx      = (r_state == c_st_load) ? r_cnt : '0;
    assign w_last_word = (w_widx == c_cnt_w'(c_words - 1));
    assign w_last_vec  = &r_v;
    assign w_query     = in_valid &&
                         (((r_state == c_st_ready) && !w_xfer) || (r_state == c_st_sweep));

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        assign w_lookup[o] = r_genome[o*T + int'(in_vec)];
        assign w_hit[o]    = (r_genome[o*T + int'(r_v)] == target_tbl[o*T + int'(r_v)]);
    end

    always_comb begin
        w_match = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            w_match = w_match + c_match_w'(w_hit[o]);
        end
    end

    assign w_final = r_acc + SCORE_W'(w_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_empty, c_st_load: begin
                if (w_xfer) begin
                    w_next = w_last_word ? c_st_ready : c_st_load;
                end
            end
            c_st_ready: begin
                if (w_xfer) begin
                    w_next = w_last_word ? c_st_ready : c_st_load;
                end else if (eval_start) begin
                    w_next = c_st_sweep;
                end
            end
            c_st_sweep: begin
                if (w_last_vec) begin
                    w_next = c_st_ready;
                end
            end
            default: w_next = c_st_empty;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state != c_st_sweep);
        eval_busy = (r_state == c_st_sweep);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_genome  <= '0;
            r_cnt     <= '0;
            r_v       <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            eval_done <= 1'b0;
            score     <= '0;
        end else begin
            out_valid <= w_query;
            if (w_query) begin
                out_vec <= w_lookup;
            end

            if (w_xfer) begin
                r_genome[int'(w_widx)*CFG_W +: CFG_W] <= cfg_data;
                r_cnt <= w_last_word ? '0 : w_widx + c_cnt_w'(1);
            end

            eval_done <= 1'b0;
            if ((r_state == c_st_ready) && !w_xfer && eval_start) begin
                r_v   <= '0;
                r_acc <= '0;
            end else if (r_state == c_st_sweep) begin
                r_v   <= r_v + NUM_IN'(1);
                r_acc <= w_final;
                if (w_last_vec) begin
                    score     <= w_final;
                    eval_done <= 1'b1;
                end
            end
        end
    end

`ifdef BOOL_LUT_BEST_EN
    // Updated alongside score so best_score is already current during the eval_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_score <= '0;
        end else if ((r_state == c_st_sweep) && w_last_vec && (w_final > best_score)) begin
            best_score <= w_final;
        end
    end
`endif

endmodule
`default_nettype wire
